// File: rtl/issue_queue_int_param.sv
// Age-ordered integer issue queue with CDB wakeup, dispatch bypass
// and full compaction every cycle (slot 0 is always the oldest).
module issue_queue_int_param #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int OPC_W  = 3,
  parameter int SHF_W  = 5,
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Dispatch_Enable,
  input  logic [TAG_W-1:0]  Dispatch_Rd_Tag,
  input  logic [TAG_W-1:0]  Dispatch_Rs_Tag,
  input  logic [DATA_W-1:0] Dispatch_Rs_Data,
  input  logic              Dispatch_Rs_Data_Val,
  input  logic [TAG_W-1:0]  Dispatch_Rt_Tag,
  input  logic [DATA_W-1:0] Dispatch_Rt_Data,
  input  logic              Dispatch_Rt_Data_Val,
  input  logic [OPC_W-1:0]  Dispatch_Opcode,
  input  logic [SHF_W-1:0]  Dispatch_Shfamt,
  output logic              IssueQue_Full,
  output logic [CNT_W-1:0]  IssueQue_Count,
  input  logic              CDB_Valid,
  input  logic [TAG_W-1:0]  CDB_Tag,
  input  logic [DATA_W-1:0] CDB_Data,
  output logic              IssueQue_Ready,
  output logic [DATA_W-1:0] IssueQue_Rs_Data,
  output logic [DATA_W-1:0] IssueQue_Rt_Data,
  output logic [TAG_W-1:0]  IssueQue_Rd_Tag,
  output logic [OPC_W-1:0]  IssueQue_Opcode,
  output logic [SHF_W-1:0]  IssueQue_Shfamt,
  input  logic              Issueblk_Issue,
  input  logic              RB_Flush_Valid
);

  localparam int SEL_W = $clog2(DEPTH);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  rs_val_q, rs_val_d;
  logic [DEPTH-1:0]  rt_val_q, rt_val_d;
  logic [TAG_W-1:0]  rd_tag_q [DEPTH];
  logic [TAG_W-1:0]  rd_tag_d [DEPTH];
  logic [TAG_W-1:0]  rs_tag_q [DEPTH];
  logic [TAG_W-1:0]  rs_tag_d [DEPTH];
  logic [TAG_W-1:0]  rt_tag_q [DEPTH];
  logic [TAG_W-1:0]  rt_tag_d [DEPTH];
  logic [DATA_W-1:0] rs_dat_q [DEPTH];
  logic [DATA_W-1:0] rs_dat_d [DEPTH];
  logic [DATA_W-1:0] rt_dat_q [DEPTH];
  logic [DATA_W-1:0] rt_dat_d [DEPTH];
  logic [OPC_W-1:0]  opc_q    [DEPTH];
  logic [OPC_W-1:0]  opc_d    [DEPTH];
  logic [SHF_W-1:0]  shf_q    [DEPTH];
  logic [SHF_W-1:0]  shf_d    [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;

  logic [DEPTH-1:0]  ready;
  logic [SEL_W-1:0]  sel;
  logic              any_rdy;
  logic              issued;
  logic              full;
  logic              accepted;
  logic [CNT_W-1:0]  wr_idx;
  logic              new_rs_v, new_rt_v;
  logic [DATA_W-1:0] new_rs_d, new_rt_d;

  always_comb begin
    ready   = valid_q & rs_val_q & rt_val_q;
    any_rdy = |ready;
    sel     = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (ready[i]) sel = SEL_W'(i);
    end
    issued   = Issueblk_Issue & any_rdy;
    full     = (count_q == CNT_W'(DEPTH)) & ~issued;
    accepted = Dispatch_Enable & ~full & ~RB_Flush_Valid;
    wr_idx   = count_q - CNT_W'(issued);
    if (RB_Flush_Valid)
      count_d = '0;
    else
      count_d = count_q - CNT_W'(issued) + CNT_W'(accepted);
  end

  // Dispatch-time bypass: pick up a matching CDB broadcast directly.
  always_comb begin
    new_rs_v = Dispatch_Rs_Data_Val;
    new_rs_d = Dispatch_Rs_Data;
    new_rt_v = Dispatch_Rt_Data_Val;
    new_rt_d = Dispatch_Rt_Data;
    if (!Dispatch_Rs_Data_Val && CDB_Valid &&
        CDB_Tag == Dispatch_Rs_Tag) begin
      new_rs_v = 1'b1;
      new_rs_d = CDB_Data;
    end
    if (!Dispatch_Rt_Data_Val && CDB_Valid &&
        CDB_Tag == Dispatch_Rt_Tag) begin
      new_rt_v = 1'b1;
      new_rt_d = CDB_Data;
    end
  end

  // Slot j takes slot j+1 when the issued entry sits at or below j.
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      int src;
      src = j;
      if (issued && j >= int'(sel) && j < DEPTH-1) src = j + 1;
      rd_tag_d[j] = rd_tag_q[src];
      rs_tag_d[j] = rs_tag_q[src];
      rt_tag_d[j] = rt_tag_q[src];
      rs_dat_d[j] = rs_dat_q[src];
      rt_dat_d[j] = rt_dat_q[src];
      rs_val_d[j] = rs_val_q[src];
      rt_val_d[j] = rt_val_q[src];
      opc_d[j]    = opc_q[src];
      shf_d[j]    = shf_q[src];
      if (CDB_Valid && valid_q[src] && !rs_val_q[src] &&
          rs_tag_q[src] == CDB_Tag) begin
        rs_dat_d[j] = CDB_Data;
        rs_val_d[j] = 1'b1;
      end
      if (CDB_Valid && valid_q[src] && !rt_val_q[src] &&
          rt_tag_q[src] == CDB_Tag) begin
        rt_dat_d[j] = CDB_Data;
        rt_val_d[j] = 1'b1;
      end
      if (accepted && CNT_W'(j) == wr_idx) begin
        rd_tag_d[j] = Dispatch_Rd_Tag;
        rs_tag_d[j] = Dispatch_Rs_Tag;
        rt_tag_d[j] = Dispatch_Rt_Tag;
        rs_dat_d[j] = new_rs_d;
        rt_dat_d[j] = new_rt_d;
        rs_val_d[j] = new_rs_v;
        rt_val_d[j] = new_rt_v;
        opc_d[j]    = Dispatch_Opcode;
        shf_d[j]    = Dispatch_Shfamt;
      end
      valid_d[j] = (CNT_W'(j) < count_d);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      valid_q  <= '0;
      rs_val_q <= '0;
      rt_val_q <= '0;
      count_q  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        rd_tag_q[k] <= '0;
        rs_tag_q[k] <= '0;
        rt_tag_q[k] <= '0;
        rs_dat_q[k] <= '0;
        rt_dat_q[k] <= '0;
        opc_q[k]    <= '0;
        shf_q[k]    <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      rs_val_q <= rs_val_d;
      rt_val_q <= rt_val_d;
      count_q  <= count_d;
      for (int k = 0; k < DEPTH; k++) begin
        rd_tag_q[k] <= rd_tag_d[k];
        rs_tag_q[k] <= rs_tag_d[k];
        rt_tag_q[k] <= rt_tag_d[k];
        rs_dat_q[k] <= rs_dat_d[k];
        rt_dat_q[k] <= rt_dat_d[k];
        opc_q[k]    <= opc_d[k];
        shf_q[k]    <= shf_d[k];
      end
    end
  end

  assign IssueQue_Full    = full;
  assign IssueQue_Count   = count_q;
  assign IssueQue_Ready   = any_rdy;
  assign IssueQue_Rs_Data = rs_dat_q[sel];
  assign IssueQue_Rt_Data = rt_dat_q[sel];
  assign IssueQue_Rd_Tag  = rd_tag_q[sel];
  assign IssueQue_Opcode  = opc_q[sel];
  assign IssueQue_Shfamt  = shf_q[sel];

endmodule

// File: tb/tb_issue_queue_int_param.sv
// Directed bench for issue_queue_int_param: fill, out-of-order issue,
// CDB wakeup, dispatch bypass, full+issue+dispatch, flush and reset.
module tb_issue_queue_int_param;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Dispatch_Enable = 1'b0;
  logic [4:0]  Dispatch_Rd_Tag = '0;
  logic [4:0]  Dispatch_Rs_Tag = '0;
  logic [31:0] Dispatch_Rs_Data = '0;
  logic        Dispatch_Rs_Data_Val = 1'b0;
  logic [4:0]  Dispatch_Rt_Tag = '0;
  logic [31:0] Dispatch_Rt_Data = '0;
  logic        Dispatch_Rt_Data_Val = 1'b0;
  logic [2:0]  Dispatch_Opcode = '0;
  logic [4:0]  Dispatch_Shfamt = '0;
  logic        IssueQue_Full;
  logic [2:0]  IssueQue_Count;
  logic        CDB_Valid = 1'b0;
  logic [4:0]  CDB_Tag = '0;
  logic [31:0] CDB_Data = '0;
  logic        IssueQue_Ready;
  logic [31:0] IssueQue_Rs_Data;
  logic [31:0] IssueQue_Rt_Data;
  logic [4:0]  IssueQue_Rd_Tag;
  logic [2:0]  IssueQue_Opcode;
  logic [4:0]  IssueQue_Shfamt;
  logic        Issueblk_Issue = 1'b0;
  logic        RB_Flush_Valid = 1'b0;

  int checks = 0;
  int errors = 0;

  issue_queue_int_param dut (
    .Clk(Clk), .Rst(Rst),
    .Dispatch_Enable(Dispatch_Enable),
    .Dispatch_Rd_Tag(Dispatch_Rd_Tag),
    .Dispatch_Rs_Tag(Dispatch_Rs_Tag),
    .Dispatch_Rs_Data(Dispatch_Rs_Data),
    .Dispatch_Rs_Data_Val(Dispatch_Rs_Data_Val),
    .Dispatch_Rt_Tag(Dispatch_Rt_Tag),
    .Dispatch_Rt_Data(Dispatch_Rt_Data),
    .Dispatch_Rt_Data_Val(Dispatch_Rt_Data_Val),
    .Dispatch_Opcode(Dispatch_Opcode),
    .Dispatch_Shfamt(Dispatch_Shfamt),
    .IssueQue_Full(IssueQue_Full),
    .IssueQue_Count(IssueQue_Count),
    .CDB_Valid(CDB_Valid), .CDB_Tag(CDB_Tag), .CDB_Data(CDB_Data),
    .IssueQue_Ready(IssueQue_Ready),
    .IssueQue_Rs_Data(IssueQue_Rs_Data),
    .IssueQue_Rt_Data(IssueQue_Rt_Data),
    .IssueQue_Rd_Tag(IssueQue_Rd_Tag),
    .IssueQue_Opcode(IssueQue_Opcode),
    .IssueQue_Shfamt(IssueQue_Shfamt),
    .Issueblk_Issue(Issueblk_Issue),
    .RB_Flush_Valid(RB_Flush_Valid)
  );

  always #5 Clk = ~Clk;

  // Inputs change 1 ns after the rising edge, checks 1 ns later.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    Dispatch_Enable = 1'b0;
    Issueblk_Issue  = 1'b0;
    CDB_Valid       = 1'b0;
    RB_Flush_Valid  = 1'b0;
  endtask

  task automatic disp(input logic [4:0] rd, input logic rs_v,
                      input logic [4:0] rs_tag,
                      input logic [31:0] rs_d,
                      input logic [31:0] rt_d);
    Dispatch_Enable      = 1'b1;
    Dispatch_Rd_Tag      = rd;
    Dispatch_Rs_Tag      = rs_tag;
    Dispatch_Rs_Data     = rs_d;
    Dispatch_Rs_Data_Val = rs_v;
    Dispatch_Rt_Tag      = 5'd0;
    Dispatch_Rt_Data     = rt_d;
    Dispatch_Rt_Data_Val = 1'b1;
    Dispatch_Opcode      = rd[2:0];
    Dispatch_Shfamt      = rd;
  endtask

  task automatic do_reset();
    idle();
    Rst = 1'b1;
    #3;
    Rst = 1'b0;
    tick();
  endtask

  task automatic fill4();
    for (int i = 1; i <= 4; i++) begin
      disp(5'(i), 1'b1, 5'd0, 32'(100 + i), 32'(200 + i));
      tick();
    end
    idle();
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    #3;
    checks++;
    if (IssueQue_Ready !== 1'b0 || IssueQue_Full !== 1'b0 ||
        IssueQue_Count !== 3'd0) begin
      errors++;
      $display("FAIL reset_flags got rdy=%b full=%b cnt=%0d exp 0 0 0",
               IssueQue_Ready, IssueQue_Full, IssueQue_Count);
    end
    checks++;
    if (IssueQue_Rs_Data !== 32'd0 || IssueQue_Rd_Tag !== 5'd0 ||
        IssueQue_Opcode !== 3'd0) begin
      errors++;
      $display("FAIL reset_data got rs=%h rd=%h op=%h exp 0",
               IssueQue_Rs_Data, IssueQue_Rd_Tag, IssueQue_Opcode);
    end
    Rst = 1'b0;
    tick();
  endtask

  task automatic test_fill_drop();
    fill4();
    checks++;
    if (IssueQue_Count !== 3'd4 || IssueQue_Full !== 1'b1 ||
        IssueQue_Ready !== 1'b1 || IssueQue_Rd_Tag !== 5'd1) begin
      errors++;
      $display("FAIL fill got cnt=%0d full=%b rdy=%b rd=%0d exp 4 1 1 1",
               IssueQue_Count, IssueQue_Full, IssueQue_Ready,
               IssueQue_Rd_Tag);
    end
    checks++;
    if (IssueQue_Rs_Data !== 32'd101 || IssueQue_Rt_Data !== 32'd201 ||
        IssueQue_Opcode !== 3'd1 || IssueQue_Shfamt !== 5'd1) begin
      errors++;
      $display("FAIL fill_fields got rs=%0d rt=%0d op=%0d sh=%0d exp 101 201 1 1",
               IssueQue_Rs_Data, IssueQue_Rt_Data, IssueQue_Opcode,
               IssueQue_Shfamt);
    end
    disp(5'd5, 1'b1, 5'd0, 32'd105, 32'd205);
    tick();
    idle();
    #1;
    checks++;
    if (IssueQue_Count !== 3'd4) begin
      errors++;
      $display("FAIL drop_count got %0d exp 4", IssueQue_Count);
    end
    for (int i = 1; i <= 4; i++) begin
      Issueblk_Issue = 1'b1;
      #1;
      checks++;
      if (IssueQue_Ready !== 1'b1 || IssueQue_Rd_Tag !== 5'(i)) begin
        errors++;
        $display("FAIL drop_drain got rdy=%b rd=%0d exp 1 %0d",
                 IssueQue_Ready, IssueQue_Rd_Tag, i);
      end
      tick();
    end
    idle();
    #1;
    checks++;
    if (IssueQue_Count !== 3'd0 || IssueQue_Ready !== 1'b0) begin
      errors++;
      $display("FAIL drop_empty got cnt=%0d rdy=%b exp 0 0",
               IssueQue_Count, IssueQue_Ready);
    end
  endtask

  task automatic test_ooo_issue();
    do_reset();
    disp(5'd1, 1'b0, 5'd7, 32'd0, 32'd201);
    tick();
    for (int i = 2; i <= 4; i++) begin
      disp(5'(i), 1'b1, 5'd0, 32'(100 + i), 32'(200 + i));
      tick();
    end
    idle();
    #1;
    checks++;
    if (IssueQue_Ready !== 1'b1 || IssueQue_Rd_Tag !== 5'd2) begin
      errors++;
      $display("FAIL ooo_sel got rdy=%b rd=%0d exp 1 2",
               IssueQue_Ready, IssueQue_Rd_Tag);
    end
    Issueblk_Issue = 1'b1;
    #1;
    checks++;
    if (IssueQue_Full !== 1'b0) begin
      errors++;
      $display("FAIL ooo_full got %b exp 0", IssueQue_Full);
    end
    tick();
    idle();
    #1;
    checks++;
    if (IssueQue_Count !== 3'd3 || IssueQue_Rd_Tag !== 5'd3 ||
        IssueQue_Rs_Data !== 32'd103) begin
      errors++;
      $display("FAIL ooo_next got cnt=%0d rd=%0d rs=%0d exp 3 3 103",
               IssueQue_Count, IssueQue_Rd_Tag, IssueQue_Rs_Data);
    end
  endtask

  task automatic test_cdb_wakeup();
    CDB_Valid = 1'b1;
    CDB_Tag   = 5'd7;
    CDB_Data  = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (IssueQue_Rd_Tag !== 5'd3) begin
      errors++;
      $display("FAIL cdb_same_cycle got rd=%0d exp 3", IssueQue_Rd_Tag);
    end
    tick();
    idle();
    #1;
    checks++;
    if (IssueQue_Ready !== 1'b1 || IssueQue_Rd_Tag !== 5'd1 ||
        IssueQue_Rs_Data !== 32'hDEAD_BEEF ||
        IssueQue_Rt_Data !== 32'd201) begin
      errors++;
      $display("FAIL cdb_wake got rdy=%b rd=%0d rs=%h rt=%0d exp 1 1 deadbeef 201",
               IssueQue_Ready, IssueQue_Rd_Tag, IssueQue_Rs_Data,
               IssueQue_Rt_Data);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    disp(5'd6, 1'b0, 5'd9, 32'hFFFF_FFFF, 32'd66);
    CDB_Valid = 1'b1;
    CDB_Tag   = 5'd9;
    CDB_Data  = 32'h1234;
    #1;
    checks++;
    if (IssueQue_Ready !== 1'b0) begin
      errors++;
      $display("FAIL bypass_early got rdy=%b exp 0", IssueQue_Ready);
    end
    tick();
    idle();
    #1;
    checks++;
    if (IssueQue_Ready !== 1'b1 || IssueQue_Rs_Data !== 32'h1234 ||
        IssueQue_Count !== 3'd1 || IssueQue_Rd_Tag !== 5'd6) begin
      errors++;
      $display("FAIL bypass got rdy=%b rs=%h cnt=%0d rd=%0d exp 1 1234 1 6",
               IssueQue_Ready, IssueQue_Rs_Data, IssueQue_Count,
               IssueQue_Rd_Tag);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_tag [4];
    exp_tag[0] = 5'd2;
    exp_tag[1] = 5'd3;
    exp_tag[2] = 5'd4;
    exp_tag[3] = 5'd8;
    do_reset();
    fill4();
    Issueblk_Issue = 1'b1;
    disp(5'd8, 1'b1, 5'd0, 32'd108, 32'd208);
    #1;
    checks++;
    if (IssueQue_Full !== 1'b0) begin
      errors++;
      $display("FAIL b2b_full got %b exp 0", IssueQue_Full);
    end
    tick();
    idle();
    #1;
    checks++;
    if (IssueQue_Count !== 3'd4 || IssueQue_Full !== 1'b1) begin
      errors++;
      $display("FAIL b2b_count got cnt=%0d full=%b exp 4 1",
               IssueQue_Count, IssueQue_Full);
    end
    for (int i = 0; i < 4; i++) begin
      Issueblk_Issue = 1'b1;
      #1;
      checks++;
      if (IssueQue_Ready !== 1'b1 || IssueQue_Rd_Tag !== exp_tag[i]) begin
        errors++;
        $display("FAIL b2b_drain got rdy=%b rd=%0d exp 1 %0d",
                 IssueQue_Ready, IssueQue_Rd_Tag, exp_tag[i]);
      end
      tick();
    end
    idle();
    #1;
    checks++;
    if (IssueQue_Count !== 3'd0) begin
      errors++;
      $display("FAIL b2b_empty got cnt=%0d exp 0", IssueQue_Count);
    end
  endtask

  task automatic test_flush_reset();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      disp(5'(i), 1'b1, 5'd0, 32'(100 + i), 32'(200 + i));
      tick();
    end
    disp(5'd9, 1'b1, 5'd0, 32'd109, 32'd209);
    RB_Flush_Valid = 1'b1;
    Issueblk_Issue = 1'b1;
    #1;
    checks++;
    if (IssueQue_Ready !== 1'b1 || IssueQue_Count !== 3'd3) begin
      errors++;
      $display("FAIL flush_pre got rdy=%b cnt=%0d exp 1 3",
               IssueQue_Ready, IssueQue_Count);
    end
    tick();
    idle();
    #1;
    checks++;
    if (IssueQue_Count !== 3'd0 || IssueQue_Ready !== 1'b0 ||
        IssueQue_Full !== 1'b0) begin
      errors++;
      $display("FAIL flush got cnt=%0d rdy=%b full=%b exp 0 0 0",
               IssueQue_Count, IssueQue_Ready, IssueQue_Full);
    end
    tick();
    checks++;
    if (IssueQue_Count !== 3'd0 || IssueQue_Ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_hold got cnt=%0d rdy=%b exp 0 0",
               IssueQue_Count, IssueQue_Ready);
    end
    for (int i = 1; i <= 2; i++) begin
      disp(5'(i), 1'b1, 5'd0, 32'(100 + i), 32'(200 + i));
      tick();
    end
    disp(5'd3, 1'b1, 5'd0, 32'd103, 32'd203);
    #2;
    Rst = 1'b1;
    #1;
    checks++;
    if (IssueQue_Count !== 3'd0 || IssueQue_Ready !== 1'b0 ||
        IssueQue_Full !== 1'b0 || IssueQue_Rd_Tag !== 5'd0) begin
      errors++;
      $display("FAIL rst_mid got cnt=%0d rdy=%b full=%b rd=%0d exp 0 0 0 0",
               IssueQue_Count, IssueQue_Ready, IssueQue_Full,
               IssueQue_Rd_Tag);
    end
    idle();
    #1;
    Rst = 1'b0;
    tick();
    checks++;
    if (IssueQue_Count !== 3'd0 || IssueQue_Ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_after got cnt=%0d rdy=%b exp 0 0",
               IssueQue_Count, IssueQue_Ready);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drop();
    test_ooo_issue();
    test_cdb_wakeup();
    test_bypass();
    test_back_to_back();
    test_flush_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_queue_int_param.md
Name: issue_queue_int_param

Overview:
Parametrised, age-ordered integer issue queue between Dispatch and the integer Issue Unit.
- Holds up to DEPTH renamed instructions and captures missing source operands from the CDB.
- Each cycle it presents the oldest entry whose operands are both ready.
- Fully compacts every cycle: surviving entries always occupy slots 0..count-1, with slot 0 the oldest.
- Adds a dispatch-time CDB bypass and an occupancy count.

Parameters:
DEPTH, 4, number of queue slots (≥2)
DATA_W, 32, operand data width
TAG_W, 5, physical/ROB tag width
OPC_W, 3, opcode width
SHF_W, 5, shift-amount width
CNT_W, $clog2(DEPTH+1), occupancy counter width

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  asynchronous reset, active-high
Dispatch_Enable  in  1  dispatch request
Dispatch_Rd_Tag  in  TAG_W  destination tag
Dispatch_Rs_Tag  in  TAG_W  Rs producer tag
Dispatch_Rs_Data  in  DATA_W  Rs value
Dispatch_Rs_Data_Val  in  1  Rs value valid
Dispatch_Rt_Tag  in  TAG_W  Rt producer tag
Dispatch_Rt_Data  in  DATA_W  Rt value
Dispatch_Rt_Data_Val  in  1  Rt value valid
Dispatch_Opcode  in  OPC_W  opcode
Dispatch_Shfamt  in  SHF_W  shift amount
IssueQue_Full  out  1  no slot for a dispatch this cycle
IssueQue_Count  out  CNT_W  registered number of valid entries
CDB_Valid  in  1  CDB tag/data valid
CDB_Tag  in  TAG_W  broadcast tag
CDB_Data  in  DATA_W  broadcast data
IssueQue_Ready  out  1  a ready entry is presented
IssueQue_Rs_Data  out  DATA_W  selected Rs
IssueQue_Rt_Data  out  DATA_W  selected Rt
IssueQue_Rd_Tag  out  TAG_W  selected Rd tag
IssueQue_Opcode  out  OPC_W  selected opcode
IssueQue_Shfamt  out  SHF_W  selected shift amount
Issueblk_Issue  in  1  Issue Unit consumes the presented entry this cycle
RB_Flush_Valid  in  1  flush entire queue

Behaviour:
Reset (Rst high, async):
- All slot fields and valid bits clear to 0.
- IssueQue_Ready=0, IssueQue_Full=0, IssueQue_Count=0, all data outputs 0.

Entry ready:
- ready[i] = valid[i] & rs_val[i] & rt_val[i], computed from registered state only.
- A CDB capture makes an entry issuable the following cycle. There is no CDB-to-issue bypass in the same cycle.

Select (combinational):
- sel = lowest index i with ready[i]. IssueQue_Ready=1 and all outputs are driven from slot sel.
- If no entry is ready: IssueQue_Ready=0 and outputs show slot 0 fields.

Issue:
- issued = Issueblk_Issue & IssueQue_Ready. Slot sel is removed at the next edge.
- Issueblk_Issue while IssueQue_Ready=0 is ignored.

Full:
- IssueQue_Full = (count==DEPTH) & ~issued. This is a combinational path from Issueblk_Issue.

Dispatch:
- accepted = Dispatch_Enable & ~IssueQue_Full & ~RB_Flush_Valid.
- An accepted entry is written to slot (count - issued), i.e. it lands behind all survivors.
- It is not issuable in its dispatch cycle (minimum dispatch-to-Ready latency: 1 cycle).
- Dispatch_Enable while full is dropped silently; no error flag.

Dispatch bypass:
- Condition: CDB_Valid, Dispatch_Rs_Data_Val=0 and CDB_Tag==Dispatch_Rs_Tag.
- Response: the new entry stores CDB_Data with rs_val=1. The same rule applies independently to Rt.

CDB capture:
- For every valid slot with rs_val=0 and rs_tag==CDB_Tag: rs_data<=CDB_Data, rs_val<=1. Rt independently.
- Capture applies to the entry wherever it lands after compaction in the same edge.
- Slots already holding valid data are never overwritten.

Compaction:
- Next state is the survivors (valid & not issued), in original age order, packed into slots 0..n-1, then the dispatched entry.
- Slots ≥ new count get valid=0; their other fields are don't-care but must not glitch outputs while invalid.

Count:
- IssueQue_Count next = count - issued + accepted.
- Holds in range 0..DEPTH by construction.

Flush:
- RB_Flush_Valid=1 clears every valid bit and count to 0 at the next edge.
- It overrides both same-cycle dispatch and CDB captures.
- Issue handshake in the flush cycle is still reported combinationally, but the queue empties regardless.

Simultaneous full + issue + dispatch:
- Dispatch is accepted, count stays DEPTH, and the new entry lands in slot DEPTH-1.

Reset asserted mid-operation:
- Immediate clear as above. No partially updated state persists after Rst deasserts.

Test Plan:
1. Reset, then dispatch 4 entries (tags Rd=1..4, all operands valid) with no issue. Expect: Count=4, Full=1, Ready=1 with Rd_Tag=1. A 5th dispatch (Rd=5) is dropped.
2. Out-of-order issue:
   - Stimulus: slot0 Rs unready (tag 7), slots1-3 ready (Rd=2,3,4); assert Issueblk_Issue for 1 cycle.
   - Expect: Rd_Tag=2 presented and removed, then Rd=3 presented next. Slot0 remains oldest; Count 4→3.
3. CDB wakeup: from test 2, CDB_Valid with Tag=7, Data=32'hDEAD_BEEF. Expect: the next cycle presents Rd=1 with Rs_Data=32'hDEADBEEF, taking priority over Rd=3.
4. Dispatch bypass: dispatch into an empty queue with Rs_Val=0, Rs_Tag=9, while CDB Tag=9, Data=32'h1234 the same cycle. Expect: the next cycle shows Ready=1, Rs_Data=32'h1234, Count=1.
5. Full with issue and dispatch in the same cycle. Expect: Full=0 during that cycle, dispatch accepted, Count stays 4, new Rd_Tag in slot 3; age order verified by draining all 4.
6. RB_Flush_Valid with Count=3 and a concurrent dispatch. Expect: next cycle Count=0, Ready=0, Full=0; the dispatched entry is absent. Rst mid-burst gives the same outcome asynchronously.
